// File: rtl/dbg_frame_pkg.sv
// Shared definitions for the debug frame packetizer: FSM encoding,
// default framing bytes, STAT bit positions and the byte-count helper.
package dbg_frame_pkg;

  localparam logic [7:0] HDR_DEF = 8'h55;
  localparam logic [7:0] TRL_DEF = 8'hAA;

  localparam int STAT_MATCHED = 0;
  localparam int STAT_NOFOUND = 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CS   = 3'd1,
    S_SEL  = 3'd2,
    S_STAT = 3'd3,
    S_RAND = 3'd4,
    S_CH   = 3'd5,
    S_TRL  = 3'd7
`ifdef DBG_FRAME_CSUM_EN
    ,
    S_CSUM = 3'd6
`endif
  } state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/debug_frame_packetizer_tx_issue_ctrl.sv
// Issue gate and registered byte/strobe towards the UART transmitter.
// Ports: clk, rst, i_want, i_byte, is_transmitting -> o_fire, tx_byte, transmit.
module tx_issue_ctrl
  import dbg_frame_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_want,
  input  logic [7:0] i_byte,
  input  logic       is_transmitting,
  output logic       o_fire,
  output logic [7:0] tx_byte,
  output logic       transmit
);

  // Blocking on our own strobe keeps transmit one cycle wide while the
  // transmitter has not yet raised is_transmitting.
  assign o_fire = i_want & ~is_transmitting & ~transmit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_byte  <= '0;
      transmit <= 1'b0;
    end else begin
      transmit <= o_fire;
      if (o_fire) tx_byte <= i_byte;
    end
  end

endmodule

// File: rtl/debug_frame_packetizer.sv
// Snapshots debug state and streams it as HDR,CS,SEL,STAT,RAND,CH..,[CSUM],TRL.
// Ports: clk, rst, cs_req, cs_cnt, ch_cnt, ro_sel, matched, no_found,
//  rand_bits, frame_en, is_transmitting -> tx_byte, transmit, frame_busy,
//  frame_done. Optional checksum byte: define DBG_FRAME_CSUM_EN.
module debug_frame_packetizer
  import dbg_frame_pkg::*;
#(
  parameter int         NUM_CH   = 3,
  parameter int         CNT_W    = 16,
  parameter int         SEL_W    = 12,
  parameter logic [7:0] HDR_BYTE = HDR_DEF,
  parameter logic [7:0] TRL_BYTE = TRL_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cs_req,
  input  logic [CNT_W-1:0]        cs_cnt,
  input  logic [NUM_CH*CNT_W-1:0] ch_cnt,
  input  logic [SEL_W-1:0]        ro_sel,
  input  logic                    matched,
  input  logic                    no_found,
  input  logic [7:0]              rand_bits,
  input  logic                    frame_en,
  input  logic                    is_transmitting,
  output logic [7:0]              tx_byte,
  output logic                    transmit,
  output logic                    frame_busy,
  output logic                    frame_done
);

  localparam int CB  = CNT_W / 8;
  localparam int SB  = ceil_div(SEL_W, 8);
  localparam int SBW = SB * 8;
  localparam int CHW = NUM_CH * CNT_W;

  localparam logic [2:0] CB_M1   = 3'(CB - 1);
  localparam logic [2:0] SB_M1   = 3'(SB - 1);
  localparam logic [2:0] CH_LAST = 3'(NUM_CH - 1);

  typedef logic [SBW-1:0] sel_t;

  state_t           r_state;
  logic [2:0]       r_idx;
  logic [2:0]       r_ch;
  logic [CNT_W-1:0] r_cs_hold;
  logic [CNT_W-1:0] r_cs;
  logic [SBW-1:0]   r_sel;
  logic             r_matched;
  logic             r_no_found;
  logic [7:0]       r_rand;
  logic [CHW-1:0]   r_ch_snap;
  logic             r_frame_busy;
  logic             r_frame_done;
`ifdef DBG_FRAME_CSUM_EN
  logic [7:0]       r_sum;
`endif

  logic             w_want;
  logic             w_fire;
  logic [7:0]       w_byte;
  logic [5:0]       w_ch_off;
  logic [CNT_W-1:0] w_cs_sh;
  logic [SBW-1:0]   w_sel_sh;
  logic [CHW-1:0]   w_chs_sh;

  // Byte index counts down, so the shift selects the MSB byte first.
  assign w_ch_off = 6'(r_ch) * 6'(CB) + 6'(r_idx);
  assign w_cs_sh  = r_cs >> {r_idx, 3'b000};
  assign w_sel_sh = r_sel >> {r_idx, 3'b000};
  assign w_chs_sh = r_ch_snap >> {w_ch_off, 3'b000};

  assign w_want = (r_state != S_IDLE) | frame_en;

  always_comb begin
    w_byte = '0;
    unique case (r_state)
      S_IDLE: w_byte = HDR_BYTE;
      S_CS:   w_byte = w_cs_sh[7:0];
      S_SEL:  w_byte = w_sel_sh[7:0];
      S_STAT: begin
        w_byte[STAT_MATCHED] = r_matched;
        w_byte[STAT_NOFOUND] = r_no_found;
      end
      S_RAND: w_byte = r_rand;
      S_CH:   w_byte = w_chs_sh[7:0];
`ifdef DBG_FRAME_CSUM_EN
      S_CSUM: w_byte = r_sum;
`endif
      S_TRL:  w_byte = TRL_BYTE;
      default: w_byte = '0;
    endcase
  end

  tx_issue_ctrl u_issue (
    .clk             (clk),
    .rst             (rst),
    .i_want          (w_want),
    .i_byte          (w_byte),
    .is_transmitting (is_transmitting),
    .o_fire          (w_fire),
    .tx_byte         (tx_byte),
    .transmit        (transmit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_ch         <= '0;
      r_cs_hold    <= '0;
      r_cs         <= '0;
      r_sel        <= '0;
      r_matched    <= 1'b0;
      r_no_found   <= 1'b0;
      r_rand       <= '0;
      r_ch_snap    <= '0;
      r_frame_busy <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef DBG_FRAME_CSUM_EN
      r_sum        <= '0;
`endif
    end else begin
      if (cs_req) r_cs_hold <= cs_cnt;
      r_frame_done <= 1'b0;
      if (w_fire) begin
`ifdef DBG_FRAME_CSUM_EN
        if (r_state != S_IDLE && r_state != S_CSUM && r_state != S_TRL)
          r_sum <= r_sum + w_byte;
`endif
        unique case (r_state)
          S_IDLE: begin
            // cs_hold is read before any same-cycle cs_req update lands.
            r_cs         <= r_cs_hold;
            r_sel        <= sel_t'(ro_sel);
            r_matched    <= matched;
            r_no_found   <= no_found;
            r_rand       <= rand_bits;
            r_ch_snap    <= ch_cnt;
            r_frame_busy <= 1'b1;
            r_idx        <= CB_M1;
            r_state      <= S_CS;
`ifdef DBG_FRAME_CSUM_EN
            r_sum        <= '0;
`endif
          end
          S_CS: begin
            if (r_idx == 3'd0) begin
              r_idx   <= SB_M1;
              r_state <= S_SEL;
            end else begin
              r_idx <= r_idx - 3'd1;
            end
          end
          S_SEL: begin
            if (r_idx == 3'd0) r_state <= S_STAT;
            else r_idx <= r_idx - 3'd1;
          end
          S_STAT: r_state <= S_RAND;
          S_RAND: begin
            r_ch    <= '0;
            r_idx   <= CB_M1;
            r_state <= S_CH;
          end
          S_CH: begin
            if (r_idx != 3'd0) begin
              r_idx <= r_idx - 3'd1;
            end else if (r_ch == CH_LAST) begin
`ifdef DBG_FRAME_CSUM_EN
              r_state <= S_CSUM;
`else
              r_state <= S_TRL;
`endif
            end else begin
              r_ch  <= r_ch + 3'd1;
              r_idx <= CB_M1;
            end
          end
`ifdef DBG_FRAME_CSUM_EN
          S_CSUM: r_state <= S_TRL;
`endif
          S_TRL: begin
            r_frame_busy <= 1'b0;
            r_frame_done <= 1'b1;
            r_state      <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign frame_busy = r_frame_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_debug_frame_packetizer.sv
// Bench for debug_frame_packetizer: frame model plus per-cycle compare.
// Honours DBG_FRAME_CSUM_EN to match the build.
module tb_debug_frame_packetizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_req = 1'b0;
  logic [15:0] cs_cnt = '0;
  logic [47:0] ch_cnt = '0;
  logic [11:0] ro_sel = '0;
  logic        matched = 1'b0;
  logic        no_found = 1'b0;
  logic [7:0]  rand_bits = '0;
  logic        frame_en = 1'b0;
  logic        force_busy = 1'b0;
  logic        is_transmitting;
  logic [7:0]  tx_byte;
  logic        transmit;
  logic        frame_busy;
  logic        frame_done;

  typedef struct packed {
    logic [7:0] b;
    logic       first;
    logic       last;
  } exp_t;
  typedef logic [7:0] bq_t[$];

  exp_t exp_q[$];
  int rd_ptr = 0;
  int hdr_cnt = 0;
  int done_cnt = 0;
  int tx_total = 0;
  int bcnt = 0;
  bit in_frame = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  assign is_transmitting = force_busy | (bcnt != 0);

  always #5 clk = ~clk;

  debug_frame_packetizer dut (
    .clk             (clk),
    .rst             (rst),
    .cs_req          (cs_req),
    .cs_cnt          (cs_cnt),
    .ch_cnt          (ch_cnt),
    .ro_sel          (ro_sel),
    .matched         (matched),
    .no_found        (no_found),
    .rand_bits       (rand_bits),
    .frame_en        (frame_en),
    .is_transmitting (is_transmitting),
    .tx_byte         (tx_byte),
    .transmit        (transmit),
    .frame_busy      (frame_busy),
    .frame_done      (frame_done)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Frame as the bytes the spec lists, built field by field.
  function automatic bq_t frame_bytes(input logic [15:0] cs,
                                      input logic [11:0] sel,
                                      input logic m, input logic nf,
                                      input logic [7:0] rnd,
                                      input logic [47:0] ch);
    bq_t q;
    logic [15:0] c;
    logic [7:0] s;
    q.push_back(8'h55);
    q.push_back(cs[15:8]);
    q.push_back(cs[7:0]);
    q.push_back({4'h0, sel[11:8]});
    q.push_back(sel[7:0]);
    q.push_back({6'b0, nf, m});
    q.push_back(rnd);
    for (int k = 0; k < 3; k++) begin
      c = ch[k*16 +: 16];
      q.push_back(c[15:8]);
      q.push_back(c[7:0]);
    end
`ifdef DBG_FRAME_CSUM_EN
    s = 8'h00;
    for (int i = 1; i < q.size(); i++) s = s + q[i];
    q.push_back(s);
`else
    s = 8'h00;
`endif
    q.push_back(8'hAA);
    return q;
  endfunction

  task automatic push_frame(input logic [15:0] cs);
    bq_t q;
    exp_t e;
    q = frame_bytes(cs, ro_sel, matched, no_found, rand_bits, ch_cnt);
    for (int i = 0; i < q.size(); i++) begin
      e.b = q[i];
      e.first = (i == 0);
      e.last = (i == q.size() - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_hdr(input int target, input int lim);
    for (int i = 0; i < lim && hdr_cnt < target; i++) step();
    chk("hdr_timeout", 64'(hdr_cnt >= target), 64'd1);
  endtask

  task automatic wait_done(input int target, input int lim);
    for (int i = 0; i < lim && done_cnt < target; i++) step();
    chk("done_timeout", 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic wait_quiet();
    for (int i = 0; i < 50 && (is_transmitting || transmit); i++) step();
    chk("quiet_timeout", 64'(is_transmitting | transmit), 64'd0);
  endtask

  task automatic run_frame(input logic [15:0] cs);
    int h, d;
    h = hdr_cnt;
    d = done_cnt;
    push_frame(cs);
    frame_en = 1'b1;
    wait_hdr(h + 1, 200);
    frame_en = 1'b0;
    wait_done(d + 1, 400);
  endtask

  // Compare process and transmitter model (busy 10 cycles per byte).
  initial begin
    logic pe_itx, pe_tx, last_now;
    exp_t e;
    forever begin
      @(posedge clk);
      pe_itx = is_transmitting;
      pe_tx = transmit;
      @(negedge clk);
      if (rst) begin
        rd_ptr = exp_q.size();
        in_frame = 1'b0;
        bcnt = 0;
      end else begin
        last_now = 1'b0;
        if (transmit) begin
          tx_total++;
          chk("issue_rule", 64'({pe_itx, pe_tx}), 64'd0);
          if (rd_ptr >= exp_q.size()) begin
            chk("unexpected_byte", 64'(tx_byte), 64'h100);
          end else begin
            e = exp_q[rd_ptr];
            rd_ptr++;
            chk("tx_byte", 64'(tx_byte), 64'(e.b));
            if (e.first) begin
              in_frame = 1'b1;
              hdr_cnt++;
            end
            if (e.last) begin
              in_frame = 1'b0;
              done_cnt++;
              last_now = 1'b1;
            end
          end
        end
        chk("frame_done", 64'(frame_done), 64'(last_now));
        chk("frame_busy", 64'(frame_busy), 64'(in_frame));
        if (transmit) bcnt = 10;
        else if (bcnt > 0) bcnt--;
      end
    end
  end

  initial begin
    bq_t q;
    logic [7:0] lit [14];
    int h, start, t0;

    #2;
    chk("rst_transmit", 64'(transmit), 64'd0);
    chk("rst_tx_byte", 64'(tx_byte), 64'd0);
    chk("rst_busy", 64'(frame_busy), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);

    // Pin the model against hand-written frames.
    q = frame_bytes(16'h1234, 12'hABC, 1'b1, 1'b0, 8'h5A,
                    {16'h0506, 16'h0304, 16'h0102});
    lit = '{8'h55, 8'h12, 8'h34, 8'h0A, 8'hBC, 8'h01, 8'h5A,
            8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hAA};
`ifdef DBG_FRAME_CSUM_EN
    chk("model_len", 64'(q.size()), 64'd15);
    chk("model_csum", 64'(q[13]), 64'h7C);
`else
    chk("model_len", 64'(q.size()), 64'd14);
`endif
    for (int i = 0; i < 13; i++) chk("model_byte", 64'(q[i]), 64'(lit[i]));
    chk("model_trl", 64'(q[q.size()-1]), 64'hAA);
    q = frame_bytes(16'h0, 12'h0, 1'b0, 1'b1, 8'h0, 48'h0);
    chk("model_stat_nf", 64'(q[5]), 64'h02);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) step();
    chk("idle_no_tx", 64'(tx_total), 64'd0);

    // 1: basic frame, cs_hold latched earlier then cs_cnt moves on.
    cs_cnt = 16'h1234;
    cs_req = 1'b1;
    step();
    cs_req = 1'b0;
    cs_cnt = 16'hFFFF;
    ro_sel = 12'hABC;
    matched = 1'b1;
    no_found = 1'b0;
    rand_bits = 8'h5A;
    ch_cnt = {16'h0506, 16'h0304, 16'h0102};
    run_frame(16'h1234);

    // 3: inputs churn every cycle after the header.
    wait_quiet();
    cs_cnt = 16'hBEEF;
    cs_req = 1'b1;
    step();
    cs_req = 1'b0;
    ro_sel = 12'h3C5;
    matched = 1'b0;
    no_found = 1'b1;
    rand_bits = 8'hC3;
    ch_cnt = {16'hDEAD, 16'h0FF0, 16'h7001};
    h = hdr_cnt;
    t0 = done_cnt;
    push_frame(16'hBEEF);
    frame_en = 1'b1;
    wait_hdr(h + 1, 200);
    frame_en = 1'b0;
    for (int i = 0; i < 400 && done_cnt <= t0; i++) begin
      step();
      cs_req = 1'($urandom);
      cs_cnt = 16'($urandom);
      ro_sel = 12'($urandom);
      matched = 1'($urandom);
      no_found = 1'($urandom);
      rand_bits = 8'($urandom);
      ch_cnt = {16'($urandom), 16'($urandom), 16'($urandom)};
    end
    chk("churn_done", 64'(done_cnt > t0), 64'd1);
    cs_req = 1'b0;

    // 4: frame_en held high for three back-to-back frames.
    wait_quiet();
    cs_cnt = 16'h00FF;
    cs_req = 1'b1;
    step();
    cs_req = 1'b0;
    ro_sel = 12'h001;
    matched = 1'b1;
    no_found = 1'b1;
    rand_bits = 8'h80;
    ch_cnt = {16'h1111, 16'h2222, 16'h3333};
    h = hdr_cnt;
    t0 = done_cnt;
    for (int k = 0; k < 3; k++) push_frame(16'h00FF);
    frame_en = 1'b1;
    wait_hdr(h + 3, 800);
    frame_en = 1'b0;
    wait_done(t0 + 3, 400);

    // 7: extremes; cs_req coincident with snapshot keeps the old hold.
    wait_quiet();
    cs_cnt = 16'h8001;
    cs_req = 1'b1;
    step();
    ro_sel = 12'hFFF;
    matched = 1'b0;
    no_found = 1'b1;
    rand_bits = 8'hFF;
    ch_cnt = {16'hFFFF, 16'h0000, 16'h8001};
    cs_cnt = 16'h7FFE;
    h = hdr_cnt;
    t0 = done_cnt;
    push_frame(16'h8001);
    frame_en = 1'b1;
    step();
    cs_req = 1'b0;
    wait_hdr(h + 1, 200);
    frame_en = 1'b0;
    wait_done(t0 + 1, 400);

    // 5: reset after the sixth byte, then a clean frame from HDR.
    wait_quiet();
    ro_sel = 12'h456;
    matched = 1'b1;
    no_found = 1'b0;
    rand_bits = 8'h11;
    ch_cnt = {16'hA0A0, 16'hB0B0, 16'hC0C0};
    start = exp_q.size();
    h = hdr_cnt;
    push_frame(16'h7FFE);
    frame_en = 1'b1;
    wait_hdr(h + 1, 200);
    frame_en = 1'b0;
    for (int i = 0; i < 200 && rd_ptr < start + 6; i++) step();
    chk("sixth_byte", 64'(rd_ptr >= start + 6), 64'd1);
    chk("pre_rst_transmit", 64'(transmit), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_transmit", 64'(transmit), 64'd0);
    chk("arst_tx_byte", 64'(tx_byte), 64'd0);
    chk("arst_busy", 64'(frame_busy), 64'd0);
    chk("arst_done", 64'(frame_done), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    run_frame(16'h0000);

    // 6: transmitter busy when frame_en rises.
    wait_quiet();
    force_busy = 1'b1;
    t0 = tx_total;
    h = hdr_cnt;
    rand_bits = 8'h3E;
    push_frame(16'h0000);
    frame_en = 1'b1;
    repeat (20) step();
    chk("held_off", 64'(tx_total), 64'(t0));
    force_busy = 1'b0;
    wait_hdr(h + 1, 50);
    frame_en = 1'b0;
    wait_done(done_cnt + 1, 400);

    repeat (15) step();
    chk("queue_drained", 64'(rd_ptr), 64'(exp_q.size()));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
